md_sequencer: RTL and testbench

// Multi-cycle multiply/divide sequencer for the E stage of the 5-stage MIPS pipeline.

---
 rtl/md_sequencer.sv | 119 +++++++++++
 tb/tb_md_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - E-stage multiply/divide sequencer owning HI/LO with fixed-latency busy window
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDOp,
    input  logic        E_Valid,
    input  logic [31:0] E_RS,
    input  logic [31:0] E_RT,
    input  logic        D_MDUse,
    output logic        E_Start,
    output logic        E_Busy,
    output logic        D_StallMD,
    output logic [31:0] E_MDRe,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = ($clog2(MAX_CYCLES + 1) < 3) ? 3 : $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [31:0]   rs_q, rt_q;
    logic [3:0]    op_q;
    logic [31:0]   hi, lo;

    logic [3:0]    op;
    logic          is_start;

    // A bubble never issues, whatever op code it carries
    assign op       = E_Valid ? E_MDOp : 4'd0;
    assign is_start = (op >= OP_MULT) && (op <= OP_DIVU);
    assign E_Start  = is_start && (state == IDLE);
    assign E_Busy   = (state == BUSY);
    assign D_StallMD = D_MDUse && (E_Start || E_Busy);
    assign E_MDRe   = (op == OP_MFHI) ? hi : (op == OP_MFLO) ? lo : 32'd0;
    assign E_HI     = hi;
    assign E_LO     = lo;

    // Sign-extending for mult lets one 64-bit multiplier serve both signednesses
    logic [63:0] mul_a, mul_b, product;
    logic        signed_div, neg_rs, neg_rt;
    logic [31:0] abs_rs, abs_rt, divisor, uq, ur, quot, rem;

    always_comb begin
        mul_a = (op_q == OP_MULT) ? {{32{rs_q[31]}}, rs_q} : {32'd0, rs_q};
        mul_b = (op_q == OP_MULT) ? {{32{rt_q[31]}}, rt_q} : {32'd0, rt_q};
        product = mul_a * mul_b;

        signed_div = (op_q == OP_DIV);
        neg_rs  = signed_div && rs_q[31];
        neg_rt  = signed_div && rt_q[31];
        abs_rs  = neg_rs ? (32'd0 - rs_q) : rs_q;
        abs_rt  = neg_rt ? (32'd0 - rt_q) : rt_q;
        divisor = (abs_rt == 32'd0) ? 32'd1 : abs_rt;
        uq      = abs_rs / divisor;
        ur      = abs_rs % divisor;
        // Magnitude 0x80000000 negates back onto itself, giving the no-trap overflow result
        quot    = (neg_rs ^ neg_rt) ? (32'd0 - uq) : uq;
        rem     = neg_rs ? (32'd0 - ur) : ur;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            rs_q  <= 32'd0;
            rt_q  <= 32'd0;
            op_q  <= 4'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (E_Start) begin
                        rs_q  <= E_RS;
                        rt_q  <= E_RT;
                        op_q  <= op;
                        count <= (op <= OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        state <= BUSY;
                    end else if (op == OP_MTHI) begin
                        hi <= E_RS;
                    end else if (op == OP_MTLO) begin
                        lo <= E_RS;
                    end
                end
                BUSY: begin
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= IDLE;
                        if (op_q == OP_MULT || op_q == OP_MULTU) begin
                            hi <= product[63:32];
                            lo <= product[31:0];
                        end else if (rt_q != 32'd0) begin
                            hi <= rem;
                            lo <= quot;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - directed bench for md_sequencer with cycle-level behavioural model
module tb_md_sequencer;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_MDOp;
    logic        E_Valid;
    logic [31:0] E_RS, E_RT;
    logic        D_MDUse;
    logic        E_Start, E_Busy, D_StallMD;
    logic [31:0] E_MDRe, E_HI, E_LO;

    md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .E_MDOp(E_MDOp), .E_Valid(E_Valid),
        .E_RS(E_RS), .E_RT(E_RT), .D_MDUse(D_MDUse),
        .E_Start(E_Start), .E_Busy(E_Busy), .D_StallMD(D_StallMD),
        .E_MDRe(E_MDRe), .E_HI(E_HI), .E_LO(E_LO)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pending result with the cycle it lands on, plus architectural HI/LO
    longint      cyc = 0;
    bit          pend = 0;
    longint      done_cyc = 0;
    bit          pend_write = 0;
    logic [31:0] pend_hi, pend_lo;
    logic [31:0] m_hi = 0, m_lo = 0;
    bit          started = 0;

    always @(posedge clk) begin
        logic [3:0] op;
        bit idle_before;
        longint a, b, q, r;
        logic [63:0] p;
        cyc++;
        op = E_Valid ? E_MDOp : 4'd0;
        if (reset) begin
            pend = 0; m_hi = 0; m_lo = 0; started = 1;
        end else begin
            idle_before = !pend;
            if (pend && cyc == done_cyc) begin
                pend = 0;
                if (pend_write) begin m_hi = pend_hi; m_lo = pend_lo; end
            end
            if (idle_before) begin
                case (op)
                    4'd1, 4'd2: begin
                        a = (op == 1) ? longint'($signed(E_RS)) : longint'({32'd0, E_RS});
                        b = (op == 1) ? longint'($signed(E_RT)) : longint'({32'd0, E_RT});
                        p = a * b;
                        pend = 1; done_cyc = cyc + MC; pend_write = 1;
                        pend_hi = p[63:32]; pend_lo = p[31:0];
                    end
                    4'd3, 4'd4: begin
                        a = (op == 3) ? longint'($signed(E_RS)) : longint'({32'd0, E_RS});
                        b = (op == 3) ? longint'($signed(E_RT)) : longint'({32'd0, E_RT});
                        pend = 1; done_cyc = cyc + DC; pend_write = (b != 0);
                        if (b != 0) begin
                            q = a / b; r = a % b;
                            pend_hi = r[31:0]; pend_lo = q[31:0];
                        end
                    end
                    4'd7: m_hi = E_RS;
                    4'd8: m_lo = E_RS;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] op;
        bit exp_start;
        if (started) begin
            op = E_Valid ? E_MDOp : 4'd0;
            exp_start = (op >= 1 && op <= 4) && !pend;
            chk("start", {31'd0, E_Start}, {31'd0, exp_start});
            chk("busy", {31'd0, E_Busy}, {31'd0, pend});
            chk("stall", {31'd0, D_StallMD}, {31'd0, D_MDUse && (exp_start || pend)});
            chk("mdre", E_MDRe, (op == 5) ? m_hi : (op == 6) ? m_lo : 32'd0);
            chk("hi", E_HI, m_hi);
            chk("lo", E_LO, m_lo);
        end
    end

    task automatic drive(input logic [3:0] op, input logic v, input logic [31:0] rs, input logic [31:0] rt);
        E_MDOp = op; E_Valid = v; E_RS = rs; E_RT = rt;
    endtask

    // Present an op for one cycle; returns just after the edge that consumed it
    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        @(posedge clk); #1 drive(op, 1'b1, rs, rt);
        @(posedge clk); #1 drive(4'd0, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A);
    endtask

    task automatic busy_len(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (E_Busy) n++;
            else break;
        end
    endtask

    int n;

    initial begin
        reset = 1'b1; D_MDUse = 1'b0;
        drive(4'd0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, E_Busy}, 32'd0);
        chk("rst_hi", E_HI, 32'd0);

        // mult -2 * 3
        issue(4'd1, 32'hFFFFFFFE, 32'd3);
        busy_len(n);
        chk("mult_len", n, 5);
        chk("mult_hi", E_HI, 32'hFFFFFFFF);
        chk("mult_lo", E_LO, 32'hFFFFFFFA);

        // divu 7/2 with a stray mtlo and changing operands while busy
        @(posedge clk); #1 drive(4'd4, 1'b1, 32'd7, 32'd2);
        @(posedge clk); #1 drive(4'd8, 1'b1, 32'hDEAD, 32'd9);
        @(posedge clk); #1 drive(4'd0, 1'b0, 32'd100, 32'd0);
        busy_len(n);
        chk("divu_len", n, 9);
        chk("divu_lo", E_LO, 32'd3);
        chk("divu_hi", E_HI, 32'd1);

        issue(4'd3, 32'hFFFFFFF9, 32'd2);
        busy_len(n);
        chk("div_len", n, 10);
        chk("div_lo", E_LO, 32'hFFFFFFFD);
        chk("div_hi", E_HI, 32'hFFFFFFFF);

        issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
        busy_len(n);
        chk("ovf_lo", E_LO, 32'h80000000);
        chk("ovf_hi", E_HI, 32'd0);

        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        busy_len(n);
        chk("multu_hi", E_HI, 32'hFFFFFFFE);
        chk("multu_lo", E_LO, 32'd1);

        // divide by zero leaves preset HI/LO alone
        issue(4'd7, 32'd5, 32'd0);
        issue(4'd8, 32'd6, 32'd0);
        issue(4'd3, 32'd9, 32'd0);
        busy_len(n);
        chk("dz_len", n, 10);
        chk("dz_hi", E_HI, 32'd5);
        chk("dz_lo", E_LO, 32'd6);

        // stall window with D_MDUse held
        @(posedge clk); #1 D_MDUse = 1'b1; drive(4'd1, 1'b1, 32'd4, 32'd4);
        n = 0;
        @(negedge clk); if (D_StallMD) n++;
        @(posedge clk); #1 drive(4'd0, 1'b0, 32'd0, 32'd0);
        repeat (11) begin @(negedge clk); if (D_StallMD) n++; end
        chk("stall_len", n, 6);
        @(posedge clk); #1 D_MDUse = 1'b0; drive(4'd1, 1'b1, 32'd4, 32'd4);
        n = 0;
        @(negedge clk); if (D_StallMD) n++;
        @(posedge clk); #1 drive(4'd0, 1'b0, 32'd0, 32'd0);
        repeat (7) begin @(negedge clk); if (D_StallMD) n++; end
        chk("nostall", n, 0);
        chk("sq_lo", E_LO, 32'd16);

        // reset on busy cycle 3 aborts the divide
        issue(4'd3, 32'd100, 32'd7);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, E_Busy}, 32'd0);
        chk("abort_hi", E_HI, 32'd0);
        chk("abort_lo", E_LO, 32'd0);
        issue(4'd2, 32'd2, 32'd3);
        busy_len(n);
        chk("post_lo", E_LO, 32'd6);

        // mthi then mfhi; invalid / bubble ops never start
        issue(4'd7, 32'h1234, 32'd0);
        #1 drive(4'd5, 1'b1, 32'd0, 32'd0);
        @(negedge clk);
        chk("mfhi", E_MDRe, 32'h1234);
        @(posedge clk); #1 drive(4'd12, 1'b1, 32'd1, 32'd1);
        @(negedge clk);
        chk("op12_start", {31'd0, E_Start}, 32'd0);
        @(posedge clk); #1 drive(4'd1, 1'b0, 32'd1, 32'd1);
        @(negedge clk);
        chk("bubble_start", {31'd0, E_Start}, 32'd0);
        @(posedge clk); #1 drive(4'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("bubble_busy", {31'd0, E_Busy}, 32'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
